alu_n_seq: RTL and testbench

Parametrised, handshaked successor to the team's 4-bit combinational ALU. It generalises operand width to `WIDTH`, keeps the nine existing opcodes, and adds three new ones: shift-left, shift-right and an iterative shift-add multiply. Results and flags are registered and delivered over a valid/ready interface, so the block drops straight into a pipelined datapath between an operand source and a result consumer.

---
 rtl/alu_n_seq.sv | 170 +++++++++++++++++
 tb/tb_alu_n_seq.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_n_seq.sv
// Parametrised ALU with a valid/ready handshake, registered result/flags,
// and an iterative shift-add multiplier (WIDTH iterations plus one load cycle).
module alu_n_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [3:0]           CTRL,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   Y,
    output logic                 zero,
    output logic                 ovf,
    output logic                 err
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD} state_e;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_NOT  = 4'b0100,
        OP_NAND = 4'b0101,
        OP_NOR  = 4'b0110,
        OP_XOR  = 4'b0111,
        OP_XNOR = 4'b1000,
        OP_MUL  = 4'b1001,
        OP_SHL  = 4'b1010,
        OP_SHR  = 4'b1011
    } op_e;

    state_e state, state_nx;

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    logic               accept;
    logic               is_mul;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   lg;
    logic [SW-1:0]      sh;
    logic [2*WIDTH-1:0] res;
    logic               res_ovf;
    logic               res_err;

    assign in_ready  = (state == S_IDLE) || ((state == S_HOLD) && out_ready);
    assign out_valid = (state == S_HOLD);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (CTRL == OP_MUL);

    // Single-cycle result, evaluated on the live operands at the accept edge
    always_comb begin
        sum     = {1'b0, A} + {1'b0, B};
        diff    = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
        sh      = B[SW-1:0];
        lg      = '0;
        res     = '0;
        res_ovf = 1'b0;
        res_err = 1'b0;
        case (op_e'(CTRL))
            OP_ADD: begin
                res     = (2*WIDTH)'(sum);
                res_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                res     = (2*WIDTH)'(diff);
                res_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  begin lg = A & B;     res = (2*WIDTH)'(lg); end
            OP_OR:   begin lg = A | B;     res = (2*WIDTH)'(lg); end
            OP_NOT:  begin lg = ~A;        res = (2*WIDTH)'(lg); end
            OP_NAND: begin lg = ~(A & B);  res = (2*WIDTH)'(lg); end
            OP_NOR:  begin lg = ~(A | B);  res = (2*WIDTH)'(lg); end
            OP_XOR:  begin lg = A ^ B;     res = (2*WIDTH)'(lg); end
            OP_XNOR: begin lg = ~(A ^ B);  res = (2*WIDTH)'(lg); end
            OP_SHL:  begin lg = A << sh;   res = (2*WIDTH)'(lg); end
            OP_SHR:  begin lg = A >> sh;   res = (2*WIDTH)'(lg); end
            OP_MUL:  res = '0;
            default: res_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nx = is_mul ? S_BUSY : S_HOLD;
                end
            end
            S_BUSY: begin
                if (cnt == '0) begin
                    state_nx = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    if (accept) begin
                        state_nx = is_mul ? S_BUSY : S_HOLD;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // The multiplicand register is shifted each iteration, so it always
    // carries the weight of the multiplier bit currently at mplier[0].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            Y      <= '0;
            zero   <= 1'b1;
            ovf    <= 1'b0;
            err    <= 1'b0;
        end else if (accept) begin
            if (is_mul) begin
                mcand  <= (2*WIDTH)'(A);
                mplier <= B;
                acc    <= '0;
                cnt    <= CW'(WIDTH);
            end else begin
                Y    <= res;
                zero <= (res == '0);
                ovf  <= res_ovf;
                err  <= res_err;
            end
        end else if (state == S_BUSY) begin
            if (cnt != '0) begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - CW'(1);
            end else begin
                Y    <= acc;
                zero <= (acc == '0);
                ovf  <= 1'b0;
                err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_n_seq.sv
// Bench for alu_n_seq (WIDTH=8): directed scenarios plus a scoreboard that
// checks every retired result against an arithmetic reference model.
module tb_alu_n_seq;

    typedef struct {
        logic [15:0] y;
        logic        zero;
        logic        ovf;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  A = '0;
    logic [7:0]  B = '0;
    logic [3:0]  CTRL = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] Y;
    logic        zero;
    logic        ovf;
    logic        err;

    int total = 0;
    int bad   = 0;
    exp_t sb[$];

    alu_n_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .CTRL      (CTRL),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y),
        .zero      (zero),
        .ovf       (ovf),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c);
        exp_t e;
        int ua, ub, sa, sb_i, s;
        logic [7:0] t;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb_i = int'($signed(b));
        e.y = '0;
        e.ovf = 1'b0;
        e.err = 1'b0;
        case (c)
            4'd0: begin e.y = 16'(ua + ub); s = sa + sb_i; e.ovf = (s > 127) || (s < -128); end
            4'd1: begin e.y = 16'((256 + ua - ub) % 512); s = sa - sb_i; e.ovf = (s > 127) || (s < -128); end
            4'd2: begin t = a & b;    e.y = {8'h00, t}; end
            4'd3: begin t = a | b;    e.y = {8'h00, t}; end
            4'd4: begin t = ~a;       e.y = {8'h00, t}; end
            4'd5: begin t = ~(a & b); e.y = {8'h00, t}; end
            4'd6: begin t = ~(a | b); e.y = {8'h00, t}; end
            4'd7: begin t = a ^ b;    e.y = {8'h00, t}; end
            4'd8: begin t = ~(a ^ b); e.y = {8'h00, t}; end
            4'd9: e.y = 16'(ua * ub);
            4'd10: e.y = 16'((ua << (ub % 8)) % 256);
            4'd11: e.y = 16'(ua >> (ub % 8));
            default: e.err = 1'b1;
        endcase
        e.zero = (e.y == 16'h0000);
        return e;
    endfunction

    // Scoreboard: a result retires at the edge following a negedge with valid && ready
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got Y=%h with empty queue", Y);
            end else begin
                e = sb.pop_front();
                if (Y !== e.y || zero !== e.zero || ovf !== e.ovf || err !== e.err) begin
                    bad++;
                    $display("FAIL sb_result: got Y=%h z=%b o=%b e=%b want Y=%h z=%b o=%b e=%b",
                             Y, zero, ovf, err, e.y, e.zero, e.ovf, e.err);
                end
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c);
        int n;
        n = 0;
        A = a; B = b; CTRL = c; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (!in_ready) begin
            bad++;
            $display("FAIL send_timeout: in_ready=%b want 1", in_ready);
        end else begin
            sb.push_back(model(a, b, c));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!out_valid && n < 60) begin
            n++;
            @(posedge clk); #1;
        end
        total++;
        if (!out_valid) begin
            bad++;
            $display("FAIL out_timeout: out_valid=%b want 1", out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || Y !== 16'h0000 || zero !== 1'b1 || ovf !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: v=%b Y=%h z=%b o=%b e=%b want 0 0000 1 0 0", out_valid, Y, zero, ovf, err);
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_add_sub();
        out_ready = 1'b1;
        send(8'd200, 8'd100, 4'b0000);
        total++;
        if (out_valid !== 1'b1 || Y !== 16'h012C || Y[8] !== 1'b1 || ovf !== 1'b0 || zero !== 1'b0) begin
            bad++;
            $display("FAIL add_200_100: v=%b Y=%h o=%b z=%b want 1 012c 0 0", out_valid, Y, ovf, zero);
        end
        send(8'd5, 8'd7, 4'b0001);
        total++;
        if (Y !== 16'h00FE || ovf !== 1'b0) begin
            bad++;
            $display("FAIL sub_5_7: Y=%h o=%b want 00fe 0", Y, ovf);
        end
        send(8'h80, 8'h01, 4'b0001);
        total++;
        if (Y !== 16'h017F || ovf !== 1'b1) begin
            bad++;
            $display("FAIL sub_80_01: Y=%h o=%b want 017f 1", Y, ovf);
        end
    endtask

    task automatic test_mul();
        out_ready = 1'b1;
        send(8'd15, 8'd17, 4'b1001);
        for (int k = 0; k <= 8; k++) begin
            total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                bad++;
                $display("FAIL mul_busy[%0d]: in_ready=%b out_valid=%b want 0 0", k, in_ready, out_valid);
            end
            @(posedge clk); #1;
        end
        total++;
        if (out_valid !== 1'b1 || Y !== 16'h00FF) begin
            bad++;
            $display("FAIL mul_15_17: v=%b Y=%h want 1 00ff", out_valid, Y);
        end
        send(8'd255, 8'd255, 4'b1001);
        wait_out();
        total++;
        if (Y !== 16'hFE01 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL mul_255_255: Y=%h o=%b want fe01 0", Y, ovf);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(8'hF0, 8'h3C, 4'b0111);
        total++;
        if (out_valid !== 1'b1 || Y !== 16'h00CC) begin
            bad++;
            $display("FAIL b2b_xor: v=%b Y=%h want 1 00cc", out_valid, Y);
        end
        send(8'h81, 8'h01, 4'b1010);
        total++;
        if (out_valid !== 1'b1 || Y !== 16'h0002) begin
            bad++;
            $display("FAIL b2b_shl: v=%b Y=%h want 1 0002", out_valid, Y);
        end
        out_ready = 1'b0;
        A = 8'h00; B = 8'h00; CTRL = 4'b0010; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || Y !== 16'h0002 || in_ready !== 1'b0 || zero !== 1'b0) begin
                bad++;
                $display("FAIL hold_frozen[%0d]: v=%b Y=%h rdy=%b z=%b want 1 0002 0 0", k, out_valid, Y, in_ready, zero);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_err_zero();
        out_ready = 1'b1;
        send(8'hAA, 8'h55, 4'b1111);
        total++;
        if (Y !== 16'h0000 || zero !== 1'b1 || err !== 1'b1 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL err_op: Y=%h z=%b e=%b o=%b want 0000 1 1 0", Y, zero, err, ovf);
        end
        send(8'hFF, 8'hFF, 4'b0101);
        total++;
        if (Y !== 16'h0000 || zero !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("FAIL nand_ff: Y=%h z=%b e=%b want 0000 1 0", Y, zero, err);
        end
    endtask

    task automatic test_random();
        out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            send(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        wait_out();
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_mul();
        out_ready = 1'b1;
        send(8'h0F, 8'h30, 4'b0011);
        @(posedge clk); #1;
        send(8'd3, 8'd3, 4'b1001);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        sb.delete();
        total++;
        if (out_valid !== 1'b0 || Y !== 16'h0000 || zero !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_mul: v=%b Y=%h z=%b want 0 0000 1", out_valid, Y, zero);
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        send(8'd1, 8'd1, 4'b0000);
        wait_out();
        total++;
        if (Y !== 16'h0002 || zero !== 1'b0) begin
            bad++;
            $display("FAIL add_after_rst: Y=%h z=%b want 0002 0", Y, zero);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_back_to_back();
        test_err_zero();
        test_random();
        test_reset_mid_mul();
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: %0d results outstanding want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
